// File: rtl/ps2_keyboard_ctrl.sv
// ps2_keyboard_ctrl: PS/2 key-event decoder with a FIFO and an LED-set command sequencer. Optional LOCK_TOGGLE_EN enables the lock-key shadow register.
module ps2_keyboard_ctrl #(
    parameter int FIFO_DEPTH  = 8,
    parameter int ACK_TIMEOUT = 2500000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] cmd_data,
    output logic       cmd_send,
    input  logic       led_req,
    input  logic [2:0] led_val,
    output logic       led_busy,
    output logic       led_err,
    output logic [2:0] lock_leds,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       fifo_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(ACK_TIMEOUT);
    localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);
    localparam logic [AW:0]   F_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SEND_CMD, WAIT_ACK1, SEND_ARG, WAIT_ACK2} state_t;

    state_t                       state_q, state_d;
    logic [7:0]                   cmd_data_q, cmd_data_d;
    logic                         cmd_send_q, cmd_send_d;
    logic                         led_busy_q, led_busy_d;
    logic                         led_err_q, led_err_d;
    logic [2:0]                   lock_q, lock_d;
    logic [2:0]                   latched_q, latched_d;
    logic                         pend_q, pend_d;
    logic [2:0]                   pend_val_q, pend_val_d;
    logic [TW-1:0]                timer_q, timer_d;
    logic [RW-1:0]                retry_q, retry_d;
    logic                         ext_q, ext_d, brk_q, brk_d;
    logic [FIFO_DEPTH-1:0][9:0]   mem_q, mem_d;
    logic [AW-1:0]                wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]                  count_q, count_d;
    logic                         ovf_q, ovf_d;
    logic                         ack_rx, nak_rx, push, pop, full, wr;
    logic                         req;
    logic [2:0]                   req_val;

    assign cmd_data  = cmd_data_q;
    assign cmd_send  = cmd_send_q;
    assign led_busy  = led_busy_q;
    assign led_err   = led_err_q;
    assign lock_leds = lock_q;
    assign {key_ext, key_break, key_code} = mem_q[rd_q];
    assign key_valid = count_q != '0;
    assign fifo_ovf  = ovf_q;

    // Byte decoder: track E0/F0 prefixes, decide which bytes become key events
    always_comb begin
        ack_rx = rx_valid && rx_data == 8'hFA;
        nak_rx = rx_valid && rx_data == 8'hFE;
        push   = rx_valid && !(rx_data inside {8'hE0, 8'hF0, 8'hAA, 8'hFC, 8'h00, 8'hFF, 8'hEE, 8'hFA, 8'hFE});
        ext_d  = ext_q;
        brk_d  = brk_q;
        if (rx_valid && rx_data == 8'hE0) ext_d = 1'b1;
        else if (rx_valid && rx_data == 8'hF0) brk_d = 1'b1;
        else if (push || (rx_valid && rx_data inside {8'hAA, 8'hFC, 8'h00, 8'hFF, 8'hEE})) {ext_d, brk_d} = 2'b00;
    end

`ifdef LOCK_TOGGLE_EN
    logic [2:0] shadow_q, shadow_d, tog_mask;
    logic       tog;
    // Lock keys flip the shadow LED state and raise an internal LED request
    always_comb begin
        tog_mask = rx_data == 8'h58 ? 3'b100 : rx_data == 8'h77 ? 3'b010 : rx_data == 8'h7E ? 3'b001 : 3'b000;
        tog      = push && !ext_q && !brk_q && tog_mask != 3'b000;
        req      = led_req || tog;
        req_val  = led_req ? led_val : shadow_q ^ tog_mask;
        shadow_d = req ? req_val : shadow_q;
    end
`else
    assign req     = led_req;
    assign req_val = led_val;
`endif

    // Show-ahead key-event FIFO with sticky overflow
    always_comb begin
        pop     = count_q != '0 && key_ready;
        full    = count_q == F_FULL;
        wr      = push && (!full || pop);
        mem_d   = mem_q;
        if (wr) mem_d[wr_q] = {ext_q, brk_q, rx_data};
        wr_d    = wr ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q + (AW + 1)'(wr) - (AW + 1)'(pop);
        ovf_d   = ovf_q || (push && full && !pop);
    end

    // LED exchange sequencer: ED, ack, value, ack with resend/timeout retries
    always_comb begin
        state_d    = state_q;
        latched_d  = latched_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        lock_d     = lock_q;
        led_err_d  = 1'b0;
        if (req && state_q != IDLE) begin
            pend_d     = 1'b1;
            pend_val_d = req_val;
        end
        case (state_q)
            IDLE: if (req || pend_q) begin
                latched_d = req ? req_val : pend_val_q;
                pend_d    = 1'b0;
                retry_d   = '0;
                state_d   = SEND_CMD;
            end
            SEND_CMD: begin
                timer_d = '0;
                state_d = WAIT_ACK1;
            end
            SEND_ARG: begin
                timer_d = '0;
                state_d = WAIT_ACK2;
            end
            WAIT_ACK1, WAIT_ACK2: begin
                timer_d = timer_q == T_MAX ? timer_q : timer_q + 1'b1;
                if (ack_rx) begin
                    retry_d = '0;
                    state_d = state_q == WAIT_ACK1 ? SEND_ARG : IDLE;
                    lock_d  = state_q == WAIT_ACK2 ? latched_q : lock_q;
                end else if (nak_rx || timer_q == T_LAST) begin
                    led_err_d = retry_q == R_MAX;
                    retry_d   = retry_q == R_MAX ? retry_q : retry_q + 1'b1;
                    state_d   = retry_q == R_MAX ? IDLE : state_q == WAIT_ACK1 ? SEND_CMD : SEND_ARG;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_send_d = state_d == SEND_CMD || state_d == SEND_ARG;
        cmd_data_d = state_d == SEND_CMD ? 8'hED : state_d == SEND_ARG ? {5'b0, latched_d} : cmd_data_q;
        led_busy_d = state_d != IDLE || pend_d;
    end

    // State registers with synchronous reset
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= IDLE;
            cmd_data_q <= '0;
            cmd_send_q <= 1'b0;
            led_busy_q <= 1'b0;
            led_err_q  <= 1'b0;
            lock_q     <= '0;
            latched_q  <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            timer_q    <= '0;
            retry_q    <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            mem_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
`ifdef LOCK_TOGGLE_EN
            shadow_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_data_q <= cmd_data_d;
            cmd_send_q <= cmd_send_d;
            led_busy_q <= led_busy_d;
            led_err_q  <= led_err_d;
            lock_q     <= lock_d;
            latched_q  <= latched_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            mem_q      <= mem_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
`ifdef LOCK_TOGGLE_EN
            shadow_q   <= shadow_d;
`endif
        end
    end
endmodule
